// File: rtl/pol2rec.sv
// pol2rec: 32-step rotation-mode CORDIC, polar (16Q16 modulus, 8Q24 degrees) to rectangular 16Q16; POL2REC_QUADEXT_EN adds a +/-90 deg pre-rotation.
// Latency 32 enabled cycles after start (enable low stalls the iteration); start restarts at any time, inputs are never back-pressured.
module pol2rec (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable,
   input  logic        start,
   input  logic [31:0] mod,
   input  logic [31:0] angle,
   output logic [31:0] x,
   output logic [31:0] y,
   output logic        busy,
   output logic        done
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t             state;
   logic        [5:0]  cnt;
   logic signed [33:0] xr, yr;
   logic signed [31:0] zr;
   logic signed [33:0] xr_nxt, yr_nxt, x_sh, y_sh;
   logic signed [31:0] zr_nxt, atan_i;
   logic signed [49:0] pre_prod;
   logic signed [33:0] pre_mod;
   logic signed [33:0] ld_x, ld_y;
   logic signed [31:0] ld_z;

   // round(atan(2^-i) * 180/pi * 2^24)
   function automatic logic signed [31:0] atan_lut(input logic [4:0] i);
      case (i)
         5'd0:    atan_lut = 32'sd754974720;
         5'd1:    atan_lut = 32'sd445687602;
         5'd2:    atan_lut = 32'sd235489088;
         5'd3:    atan_lut = 32'sd119537938;
         5'd4:    atan_lut = 32'sd60000934;
         5'd5:    atan_lut = 32'sd30029717;
         5'd6:    atan_lut = 32'sd15018523;
         5'd7:    atan_lut = 32'sd7509720;
         5'd8:    atan_lut = 32'sd3754917;
         5'd9:    atan_lut = 32'sd1877466;
         5'd10:   atan_lut = 32'sd938734;
         5'd11:   atan_lut = 32'sd469367;
         5'd12:   atan_lut = 32'sd234684;
         5'd13:   atan_lut = 32'sd117342;
         5'd14:   atan_lut = 32'sd58671;
         5'd15:   atan_lut = 32'sd29335;
         5'd16:   atan_lut = 32'sd14668;
         5'd17:   atan_lut = 32'sd7334;
         5'd18:   atan_lut = 32'sd3667;
         5'd19:   atan_lut = 32'sd1833;
         5'd20:   atan_lut = 32'sd917;
         5'd21:   atan_lut = 32'sd458;
         5'd22:   atan_lut = 32'sd229;
         5'd23:   atan_lut = 32'sd115;
         5'd24:   atan_lut = 32'sd57;
         5'd25:   atan_lut = 32'sd29;
         5'd26:   atan_lut = 32'sd14;
         5'd27:   atan_lut = 32'sd7;
         5'd28:   atan_lut = 32'sd4;
         5'd29:   atan_lut = 32'sd2;
         5'd30:   atan_lut = 32'sd1;
         default: atan_lut = 32'sd0;
      endcase
   endfunction

`ifdef POL2REC_QUADEXT_EN
   localparam logic signed [31:0] QUARTER = 32'sh5A000000;
`endif

   // Operand load: modulus scaled by 1/K so the CORDIC gain cancels out.
   always_comb begin
      pre_prod = $signed({{18{mod[31]}}, mod}) * 50'sd39797;
      pre_mod  = 34'(pre_prod >>> 16);
      ld_x     = pre_mod;
      ld_y     = '0;
      ld_z     = $signed(angle);
`ifdef POL2REC_QUADEXT_EN
      if ($signed(angle) > QUARTER) begin
         ld_x = '0;
         ld_y = pre_mod;
         ld_z = $signed(angle) - QUARTER;
      end else if ($signed(angle) < -QUARTER) begin
         ld_x = '0;
         ld_y = -pre_mod;
         ld_z = $signed(angle) + QUARTER;
      end
`endif
   end

   always_comb begin
      atan_i = atan_lut(cnt[4:0]);
      x_sh   = xr >>> cnt;
      y_sh   = yr >>> cnt;
      if (!zr[31]) begin
         xr_nxt = xr - y_sh;
         yr_nxt = yr + x_sh;
         zr_nxt = zr - atan_i;
      end else begin
         xr_nxt = xr + y_sh;
         yr_nxt = yr - x_sh;
         zr_nxt = zr + atan_i;
      end
   end

   assign busy = (state == RUN);

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         xr    <= '0;
         yr    <= '0;
         zr    <= '0;
         x     <= '0;
         y     <= '0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            // A start mid-run simply reloads; the aborted result is dropped.
            state <= RUN;
            cnt   <= '0;
            xr    <= ld_x;
            yr    <= ld_y;
            zr    <= ld_z;
         end else if (state == RUN && enable) begin
            xr <= xr_nxt;
            yr <= yr_nxt;
            zr <= zr_nxt;
            if (cnt == 6'd31) begin
               x     <= xr_nxt[31:0];
               y     <= yr_nxt[31:0];
               done  <= 1'b1;
               state <= IDLE;
               cnt   <= '0;
            end else begin
               cnt <= cnt + 6'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_pol2rec.sv
// Randomized and directed checks of pol2rec against an arithmetic CORDIC model and ideal trigonometry.
module tb_pol2rec;

   logic        clock = 1'b0;
   logic        reset, enable, start;
   logic [31:0] mod, angle, x, y;
   logic        busy, done;

   int     checks = 0;
   int     errors = 0;
   longint atan_tab[32];
   int     lat, hi, dones;
   longint ex, ey;

   pol2rec dut (
      .clock (clock),
      .reset (reset),
      .enable(enable),
      .start (start),
      .mod   (mod),
      .angle (angle),
      .x     (x),
      .y     (y),
      .busy  (busy),
      .done  (done)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input longint obs, input longint exp, input longint tol);
      longint diff;
      checks++;
      diff = obs - exp;
      if (diff < 0) diff = -diff;
      if (diff > tol) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, obs, exp, tol);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic longint wrap34(input longint v);
      logic signed [33:0] t;
      t = v[33:0];
      return longint'(t);
   endfunction

   function automatic longint wrap32(input longint v);
      logic signed [31:0] t;
      t = v[31:0];
      return longint'(t);
   endfunction

   // Bit-true CORDIC rotation: gain-compensated start vector, 32 shift-add micro-rotations.
   task automatic model(input logic [31:0] m, input logic [31:0] a, output longint mx, output longint my);
      longint vx, vy, vz, pre, sx, sy;
      logic [31:0] lo;
      pre = (longint'($signed(m)) * 39797) >>> 16;
      vx = pre;
      vy = 0;
      vz = longint'($signed(a));
`ifdef POL2REC_QUADEXT_EN
      if (vz > 64'sd1509949440) begin
         vx = 0; vy = pre; vz = vz - 64'sd1509949440;
      end else if (vz < -64'sd1509949440) begin
         vx = 0; vy = -pre; vz = vz + 64'sd1509949440;
      end
`endif
      for (int i = 0; i < 32; i++) begin
         sx = vx >>> i;
         sy = vy >>> i;
         if (vz >= 0) begin
            vx = wrap34(vx - sy); vy = wrap34(vy + sx); vz = wrap32(vz - atan_tab[i]);
         end else begin
            vx = wrap34(vx + sy); vy = wrap34(vy - sx); vz = wrap32(vz + atan_tab[i]);
         end
      end
      lo = vx[31:0]; mx = longint'($signed(lo));
      lo = vy[31:0]; my = longint'($signed(lo));
   endtask

   function automatic longint ideal(input logic [31:0] m, input logic [31:0] a, input bit want_y);
      real r, th;
      r  = $itor($signed(m));
      th = $itor($signed(a)) / 16777216.0 * 3.14159265358979323846 / 180.0;
      return want_y ? longint'(r * $sin(th)) : longint'(r * $cos(th));
   endfunction

   // en_mode: 0 = held high, 1 = low/high alternating, 2 = random
   task automatic convert(input logic [31:0] m, input logic [31:0] a, input int en_mode,
                          input string tag, output int cyc, output int en_hi);
      enable = 1'b1; mod = m; angle = a; start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 0; en_hi = 0;
      while (!done && cyc < 300) begin
         case (en_mode)
            0:       enable = 1'b1;
            1:       enable = (cyc % 2 == 1);
            default: enable = ($urandom_range(9, 0) < 7);
         endcase
         if (enable) en_hi++;
         tick();
         cyc++;
      end
      check({tag, " done"}, longint'(done), 1, 0);
   endtask

   task automatic verify(input string tag, input logic [31:0] m, input logic [31:0] a, input bit use_ideal);
      longint mx, my;
      model(m, a, mx, my);
      check({tag, " x"}, longint'($signed(x)), mx, 0);
      check({tag, " y"}, longint'($signed(y)), my, 0);
      if (use_ideal) begin
         check({tag, " x ideal"}, longint'($signed(x)), ideal(m, a, 1'b0), 16);
         check({tag, " y ideal"}, longint'($signed(y)), ideal(m, a, 1'b1), 16);
      end
   endtask

   task automatic count_done(input int n, output int cnt);
      cnt = 0;
      for (int k = 0; k < n; k++) begin
         tick();
         if (done) cnt++;
      end
   endtask

   initial begin
      logic [31:0] rm, ra;
      logic [31:0] x_hold;
      int d2;
      for (int i = 0; i < 32; i++)
         atan_tab[i] = longint'($atan($pow(2.0, -i)) * 180.0 / 3.14159265358979323846 * 16777216.0);

      reset = 1'b1; start = 1'b0; enable = 1'b0; mod = '0; angle = '0;
      repeat (3) tick();
      check("reset x", longint'(x), 0, 0);
      check("reset y", longint'(y), 0, 0);
      check("reset busy", longint'(busy), 0, 0);
      check("reset done", longint'(done), 0, 0);

      mod = 32'h00640000; start = 1'b1;
      tick();
      check("reset beats start", longint'(busy), 0, 0);
      reset = 1'b0; start = 1'b0;
      tick();

      convert(32'h00640000, 32'h00000000, 0, "a0", lat, hi);
      check("a0 latency", lat, 32, 0);
      verify("a0", 32'h00640000, 32'h00000000, 1'b1);
      x_hold = x;
      tick();
      check("a0 done pulse", longint'(done), 0, 0);
      check("a0 idle", longint'(busy), 0, 0);
      check("a0 x held", longint'(x), longint'(x_hold), 0);

      convert(32'h00640000, 32'h1E000000, 0, "a30", lat, hi);
      check("a30 latency", lat, 32, 0);
      verify("a30", 32'h00640000, 32'h1E000000, 1'b1);

      convert(32'h00640000, 32'hD3000000, 1, "m45", lat, hi);
      check("m45 latency", lat, 64, 0);
      verify("m45", 32'h00640000, 32'hD3000000, 1'b1);

`ifdef POL2REC_QUADEXT_EN
      convert(32'h00640000, 32'h78000000, 0, "q120", lat, hi);
      verify("q120", 32'h00640000, 32'h78000000, 1'b1);
      convert(32'h00640000, 32'h88000000, 0, "qm120", lat, hi);
      verify("qm120", 32'h00640000, 32'h88000000, 1'b1);
`else
      convert(32'h00640000, 32'h5A000000, 0, "a90", lat, hi);
      verify("a90", 32'h00640000, 32'h5A000000, 1'b1);
      convert(32'h00640000, 32'hA6000000, 0, "am90", lat, hi);
      verify("am90", 32'h00640000, 32'hA6000000, 1'b1);
`endif

      // Boundaries: zero modulus, maximum modulus
      convert(32'h00000000, 32'h2D000000, 0, "mod0", lat, hi);
      verify("mod0", 32'h00000000, 32'h2D000000, 1'b1);
      convert(32'h7FFF0000, 32'h00000000, 0, "modmax", lat, hi);
      verify("modmax", 32'h7FFF0000, 32'h00000000, 1'b0);

      // Restart mid-run: only the second conversion completes
      enable = 1'b1; mod = 32'h00640000; angle = 32'h1E000000; start = 1'b1;
      tick();
      start = 1'b0;
      count_done(10, dones);
      check("restart busy", longint'(busy), 1, 0);
      convert(32'h000A0000, 32'h00000000, 0, "restart", lat, hi);
      check("restart latency", lat, 32, 0);
      verify("restart", 32'h000A0000, 32'h00000000, 1'b1);
      count_done(40, d2);
      check("restart extra dones", dones + d2, 0, 0);

      // Reset during a run abandons it
      enable = 1'b1; mod = 32'h00640000; angle = 32'h1E000000; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midreset busy", longint'(busy), 0, 0);
      check("midreset x", longint'(x), 0, 0);
      check("midreset y", longint'(y), 0, 0);
      count_done(40, dones);
      check("midreset dones", dones, 0, 0);

      for (int n = 0; n < 40; n++) begin
         rm = $urandom_range(32'h7FFF0000, 0);
`ifdef POL2REC_QUADEXT_EN
         ra = $urandom;
`else
         ra = $urandom_range(32'hB4000000, 0) - 32'h5A000000;
`endif
         convert(rm, ra, 2, "rand", lat, hi);
         check("rand enabled cycles", hi, 32, 0);
         verify("rand", rm, ra, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
